execute_unit_p: RTL and testbench
=================================

EXECUTE_UNIT_P -- requirements
Module: execute_unit_p

Interface
REQ-001 Parameter W, default 64: datapath width in bits, 16 to 64 inclusive.
REQ-002 Parameter MUL_EN, default 1: 1 = OPq ifun 4 (mulq) implemented; 0 = treated as invalid ifun.
REQ-003 clk  in  1  sole clock; all state changes on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 in_valid  in  1  upstream holds a valid instruction.
REQ-006 in_ready  out  1  block accepts; transfer when in_valid&in_ready at clk edge.
REQ-007 icode, ifun  in  4 each  instruction code/function.
REQ-008 valA, valB, valC  in  W each  operands, two's complement.
REQ-009 cc_inhibit  in  1  sampled at accept; 1 = do not update CC (downstream exception).
REQ-010 out_valid  out  1  valE/cnd valid.
REQ-011 out_ready  in  1  downstream consumes; transfer when out_valid&out_ready.
REQ-012 valE  out  W  result.  cnd  out  1  condition result.
REQ-013 cc  out  3  {OF,SF,ZF} current register.  busy  out  1  multiply in progress.

Function
REQ-014 FSM states IDLE, MUL, VALID; IDLE->VALID on accepting a single-cycle op; IDLE->MUL on accepting mulq; MUL->VALID after W iteration cycles; VALID->IDLE on out_ready without new accept; VALID->VALID or VALID->MUL on out_ready with simultaneous accept.
REQ-015 in_ready = (state==IDLE) | (state==VALID & out_ready); combinational, no dependency on in_valid.
REQ-016 Single-cycle latency: result registered on accept edge, out_valid high next cycle.
REQ-017 Mulq latency: out_valid high exactly W+1 cycles after accept edge; busy high in MUL only.
REQ-018 valE, cnd, out_valid stable while out_valid & ~out_ready.
REQ-019 valE: icode 3 -> valC; 4,5 -> valB+valC; 6 -> OPq; 8,A -> valB-8; 9,B -> valB+8; 2 -> valA; all others (0,1,7,C-F) -> 0.
REQ-020 OPq: ifun 0 valB+valA; 1 valB-valA; 2 valA&valB; 3 valA^valB; 4 low W bits of valA*valB (MUL_EN=1); other ifun -> valE=0, CC unchanged.
REQ-021 All arithmetic modulo 2^W; no carry output.
REQ-022 CC updated only by icode 6 with valid ifun, at the same edge valE is registered (mulq: MUL->VALID edge), and only if cc_inhibit was 0 at accept.
REQ-023 ZF = (valE==0); SF = valE[W-1]; OF add = operands same sign & result sign differs; OF sub = valB,valA signs differ & result sign != valB sign; OF = 0 for and, xor, mulq.
REQ-024 cnd for icode 2 and 7 by ifun: 0 always 1; 1 le (SF^OF)|ZF; 2 l SF^OF; 3 e ZF; 4 ne ~ZF; 5 ge ~(SF^OF); 6 g ~(SF^OF)&~ZF; 7-F 0; cnd = 0 for all other icodes.
REQ-025 cnd evaluated with CC at the accept edge; an OPq accepted immediately before a jXX/cmov is visible to it (back-to-back, no bubble).
REQ-026 Multiplier: radix-2 shift-add, one bit of valA per cycle, W cycles, operands latched at accept.

Reset
REQ-027 rst high at a clk edge: state=IDLE, out_valid=0, valE=0, cnd=0, busy=0, multiply counter=0.
REQ-028 Reset CC = {OF=0,SF=0,ZF=1}.
REQ-029 Reset during MUL aborts the multiply; no result produced, CC not updated.
REQ-030 in_ready = 0 while rst is high.

Structure
REQ-031 Package exec_pkg holds icode constants (HALT..POPQ), OPq ifun codes, condition ifun codes, CC bit indices, and FSM state enum.
REQ-032 One sub-module exec_mul_seq (W-parameterised iterative multiplier: start, operands, done, product); condition evaluation stays inline.

Verification
REQ-033 W=64: addq valA=0x7FFF_FFFF_FFFF_FFFF, valB=1 -> valE=0x8000_0000_0000_0000, CC={1,1,0}; following jl (ifun 2) -> cnd=0, jle (ifun 1) -> cnd=0.
REQ-034 subq valA=5, valB=5, then cmove ifun 3 back-to-back -> first valE=0 with ZF=1, second cnd=1 with valE=valA.
REQ-035 W=16 mulq valA=0x0100, valB=0x0101 -> out_valid 17 cycles after accept, valE=0x0100, busy high 16 cycles, in_ready low throughout.
REQ-036 out_ready held 0 for 3 cycles after an addq result -> valE, cnd, out_valid unchanged, in_ready=0; out_ready=1 with in_valid=1 -> next instruction accepted that edge.
REQ-037 rst asserted on 5th cycle of mulq -> next cycle out_valid=0, busy=0, CC={0,0,1}, no result ever emitted.
REQ-038 xorq valA=valB=3 with cc_inhibit=1 -> valE=0, CC unchanged from prior value.

Source files
------------

// File: rtl/exec_pkg.sv
// exec_pkg: shared constants for the execute stage.
//   icode values (HALT..POPQ), OPq function codes, condition codes used by
//   cmovXX/jXX, bit positions inside the {OF,SF,ZF} condition-code register,
//   and the execute FSM state type.
package exec_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [3:0] F_ADDQ = 4'h0;
  localparam logic [3:0] F_SUBQ = 4'h1;
  localparam logic [3:0] F_ANDQ = 4'h2;
  localparam logic [3:0] F_XORQ = 4'h3;
  localparam logic [3:0] F_MULQ = 4'h4;

  localparam logic [3:0] C_YES = 4'h0;
  localparam logic [3:0] C_LE  = 4'h1;
  localparam logic [3:0] C_L   = 4'h2;
  localparam logic [3:0] C_E   = 4'h3;
  localparam logic [3:0] C_NE  = 4'h4;
  localparam logic [3:0] C_GE  = 4'h5;
  localparam logic [3:0] C_G   = 4'h6;

  localparam int CC_OF = 2;
  localparam int CC_SF = 1;
  localparam int CC_ZF = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MUL   = 2'd1,
    ST_VALID = 2'd2
  } exec_state_e;

endpackage

// File: rtl/exec_mul_seq.sv
// exec_mul_seq: radix-2 shift-add multiplier, one bit of op_a per cycle.
//   clk, rst     : clock, synchronous active-high reset
//   start        : latch op_a/op_b and begin W iterations
//   op_a, op_b   : operands (low W bits of the product are produced)
//   busy         : iterations in progress (W cycles after start)
//   done         : one-cycle pulse, product valid from this cycle on
//   product      : low W bits of op_a*op_b
module exec_mul_seq #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] op_a,
  input  logic [W-1:0] op_b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] product
);

  localparam int CW = $clog2(W) + 1;

  logic [W-1:0]  acc_q, acc_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  always_comb begin
    acc_d  = acc_q;
    a_d    = a_q;
    b_d    = b_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    done_d = 1'b0;
    if (start) begin
      acc_d  = '0;
      a_d    = op_a;
      b_d    = op_b;
      cnt_d  = '0;
      busy_d = 1'b1;
    end else if (busy_q) begin
      // Multiplier bit comes from the LSB of a; the multiplicand shifts up
      // so it always carries the weight of the bit being examined.
      if (a_q[0]) acc_d = acc_q + b_q;
      a_d   = a_q >> 1;
      b_d   = b_q << 1;
      cnt_d = cnt_q + CW'(1);
      if (cnt_q == CW'(W - 1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q  <= '0;
      a_q    <= '0;
      b_q    <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      a_q    <= a_d;
      b_q    <= b_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = acc_q;

endmodule

// File: rtl/execute_unit_p.sv
// execute_unit_p: Y86-style execute stage with a sequential mulq.
//   clk, rst               : clock, synchronous active-high reset
//   in_valid/in_ready      : instruction input handshake
//   icode, ifun            : instruction code / function
//   valA, valB, valC       : operands
//   cc_inhibit             : sampled at accept, 1 blocks the CC update
//   out_valid/out_ready    : result output handshake
//   valE, cnd              : result value and condition outcome
//   cc                     : {OF,SF,ZF} condition-code register
//   busy                   : multiplier iterating
//   dbg_state              : current FSM state
//
// Handshake: a transfer happens on a rising edge where valid & ready are both
// high. in_ready never looks at in_valid; out_valid never looks at out_ready,
// and the result holds unchanged while out_valid & ~out_ready.
module execute_unit_p
  import exec_pkg::*;
#(
  parameter int W      = 64,
  parameter int MUL_EN = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [3:0]   icode,
  input  logic [3:0]   ifun,
  input  logic [W-1:0] valA,
  input  logic [W-1:0] valB,
  input  logic [W-1:0] valC,
  input  logic         cc_inhibit,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] valE,
  output logic         cnd,
  output logic [2:0]   cc,
  output logic         busy,
  output exec_state_e  dbg_state
);

  exec_state_e  state_q, state_d;
  logic [W-1:0] val_e_q, val_e_d;
  logic         cnd_q, cnd_d;
  logic [2:0]   cc_q, cc_d;
  logic         inh_q, inh_d;   // cc_inhibit captured for an in-flight mulq

  logic         accept, is_mul, mul_start, mul_busy, mul_done;
  logic [W-1:0] mul_prod;
  logic [W-1:0] op_res, exe_val;
  logic         op_of, op_ok, cond_hit, cnd_new;
  logic         of_f, sf_f, zf_f;

  assign in_ready = ~rst & ((state_q == ST_IDLE) | ((state_q == ST_VALID) & out_ready));
  assign accept   = in_valid & in_ready;
  assign is_mul   = (MUL_EN != 0) && (icode == I_OPQ) && (ifun == F_MULQ);

  // Single-cycle OPq datapath; unknown ifun yields 0 and no CC update.
  always_comb begin
    op_res = '0;
    op_of  = 1'b0;
    op_ok  = 1'b1;
    case (ifun)
      F_ADDQ: begin
        op_res = valB + valA;
        op_of  = (valA[W-1] == valB[W-1]) && (op_res[W-1] != valA[W-1]);
      end
      F_SUBQ: begin
        op_res = valB - valA;
        op_of  = (valA[W-1] != valB[W-1]) && (op_res[W-1] != valB[W-1]);
      end
      F_ANDQ:  op_res = valA & valB;
      F_XORQ:  op_res = valA ^ valB;
      default: op_ok  = 1'b0;
    endcase
  end

  always_comb begin
    exe_val = '0;
    case (icode)
      I_RRMOVQ:           exe_val = valA;
      I_IRMOVQ:           exe_val = valC;
      I_RMMOVQ, I_MRMOVQ: exe_val = valB + valC;
      I_OPQ:              exe_val = op_res;
      I_CALL, I_PUSHQ:    exe_val = valB - W'(8);
      I_RET, I_POPQ:      exe_val = valB + W'(8);
      default:            exe_val = '0;
    endcase
  end

  // Condition uses the registered CC, which already holds the effect of an
  // OPq accepted on the previous edge.
  assign of_f = cc_q[CC_OF];
  assign sf_f = cc_q[CC_SF];
  assign zf_f = cc_q[CC_ZF];

  always_comb begin
    cond_hit = 1'b0;
    case (ifun)
      C_YES:   cond_hit = 1'b1;
      C_LE:    cond_hit = (sf_f ^ of_f) | zf_f;
      C_L:     cond_hit = sf_f ^ of_f;
      C_E:     cond_hit = zf_f;
      C_NE:    cond_hit = ~zf_f;
      C_GE:    cond_hit = ~(sf_f ^ of_f);
      C_G:     cond_hit = ~(sf_f ^ of_f) & ~zf_f;
      default: cond_hit = 1'b0;
    endcase
  end

  assign cnd_new = ((icode == I_RRMOVQ) || (icode == I_JXX)) ? cond_hit : 1'b0;

  always_comb begin
    state_d   = state_q;
    val_e_d   = val_e_q;
    cnd_d     = cnd_q;
    cc_d      = cc_q;
    inh_d     = inh_q;
    mul_start = 1'b0;
    case (state_q)
      ST_IDLE, ST_VALID: begin
        if (accept) begin
          if (is_mul) begin
            state_d   = ST_MUL;
            mul_start = 1'b1;
            inh_d     = cc_inhibit;
          end else begin
            state_d = ST_VALID;
            val_e_d = exe_val;
            cnd_d   = cnd_new;
            if ((icode == I_OPQ) && op_ok && !cc_inhibit) begin
              cc_d[CC_OF] = op_of;
              cc_d[CC_SF] = op_res[W-1];
              cc_d[CC_ZF] = (op_res == '0);
            end
          end
        end else if (state_q == ST_VALID && out_ready) begin
          state_d = ST_IDLE;
        end
      end
      ST_MUL: begin
        if (mul_done) begin
          state_d = ST_VALID;
          val_e_d = mul_prod;
          cnd_d   = 1'b0;
          if (!inh_q) begin
            cc_d[CC_OF] = 1'b0;
            cc_d[CC_SF] = mul_prod[W-1];
            cc_d[CC_ZF] = (mul_prod == '0);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      val_e_q <= '0;
      cnd_q   <= 1'b0;
      cc_q    <= 3'b001;
      inh_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      val_e_q <= val_e_d;
      cnd_q   <= cnd_d;
      cc_q    <= cc_d;
      inh_q   <= inh_d;
    end
  end

  exec_mul_seq #(.W(W)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .op_a    (valA),
    .op_b    (valB),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_prod)
  );

  assign out_valid = (state_q == ST_VALID);
  assign valE      = val_e_q;
  assign cnd       = cnd_q;
  assign cc        = cc_q;
  assign busy      = (state_q == ST_MUL) & mul_busy;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_execute_unit_p.sv
module tb_execute_unit_p;
  import exec_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- W=64 instance ----------------
  logic        in_valid = 1'b0, in_ready, cc_inhibit = 1'b0;
  logic [3:0]  icode = '0, ifun = '0;
  logic [63:0] valA = '0, valB = '0, valC = '0, valE;
  logic        out_valid, out_ready = 1'b1, cnd, busy;
  logic [2:0]  cc;
  exec_state_e dbg_state;

  execute_unit_p #(.W(64), .MUL_EN(1)) u_dut64 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .icode(icode), .ifun(ifun), .valA(valA), .valB(valB), .valC(valC),
    .cc_inhibit(cc_inhibit), .out_valid(out_valid), .out_ready(out_ready),
    .valE(valE), .cnd(cnd), .cc(cc), .busy(busy), .dbg_state(dbg_state)
  );

  // ---------------- W=16 instance ----------------
  logic        iv_s = 1'b0, ir_s, inh_s = 1'b0;
  logic [3:0]  ic_s = '0, if_s = '0;
  logic [15:0] a_s = '0, b_s = '0, c_s = '0, ve_s;
  logic        ov_s, ordy_s = 1'b1, cnd_s, busy_s;
  logic [2:0]  cc_s;
  exec_state_e st_s;

  execute_unit_p #(.W(16), .MUL_EN(1)) u_dut16 (
    .clk(clk), .rst(rst), .in_valid(iv_s), .in_ready(ir_s),
    .icode(ic_s), .ifun(if_s), .valA(a_s), .valB(b_s), .valC(c_s),
    .cc_inhibit(inh_s), .out_valid(ov_s), .out_ready(ordy_s),
    .valE(ve_s), .cnd(cnd_s), .cc(cc_s), .busy(busy_s), .dbg_state(st_s)
  );

  // ---------------- scoreboard ----------------
  int n_total = 0;
  int n_bad   = 0;
  logic [63:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Every result leaving the W=64 unit must match the next queued value.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) check("sb_extra", 64'(exp_q.size()), 64'd1);
      else                   check("sb_valE", valE, exp_q.pop_front());
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] ic, input logic [3:0] fn, input logic [63:0] a,
                      input logic [63:0] b, input logic [63:0] c, input logic inh);
    int n;
    icode = ic; ifun = fn; valA = a; valB = b; valC = c; cc_inhibit = inh;
    in_valid = 1'b1;
    #1;
    n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    check("in_ready_wait", in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [3:0] ic, input logic [3:0] fn,
                        input logic [63:0] a, input logic [63:0] b, input logic [63:0] c,
                        input logic inh, input logic [63:0] ev, input logic ec,
                        input logic [2:0] ecc);
    exp_q.push_back(ev);
    send(ic, fn, a, b, c, inh);
    check({tag, "_ov"},   out_valid, 1'b1);
    check({tag, "_valE"}, valE, ev);
    check({tag, "_cnd"},  cnd, ec);
    check({tag, "_cc"},   cc, ecc);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int busy_n, lat;
    logic rdy_seen, ov_seen;

    // reset
    rst = 1'b1;
    tick(); tick();
    check("rst_in_ready64", in_ready, 1'b0);
    check("rst_in_ready16", ir_s, 1'b0);
    check("rst_out_valid",  out_valid, 1'b0);
    check("rst_valE",       valE, 64'd0);
    check("rst_cnd",        cnd, 1'b0);
    check("rst_cc",         cc, 3'b001);
    check("rst_busy",       busy, 1'b0);
    check("rst_state",      dbg_state, ST_IDLE);
    rst = 1'b0;
    tick();
    check("idle_in_ready",  in_ready, 1'b1);

    // signed overflow on add, then conditions that read it
    run_op("addq_ovf", I_OPQ, F_ADDQ, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1'b0,
           64'h8000_0000_0000_0000, 1'b0, 3'b110);
    run_op("jl",  I_JXX, C_L,  64'd0, 64'd0, 64'h40, 1'b0, 64'd0, 1'b0, 3'b110);
    run_op("jle", I_JXX, C_LE, 64'd0, 64'd0, 64'h40, 1'b0, 64'd0, 1'b0, 3'b110);

    // zero result feeding a back-to-back cmove
    run_op("subq_z", I_OPQ, F_SUBQ, 64'd5, 64'd5, 64'd0, 1'b0, 64'd0, 1'b0, 3'b001);
    run_op("cmove",  I_RRMOVQ, C_E, 64'h1234, 64'd0, 64'd0, 1'b0, 64'h1234, 1'b1, 3'b001);

    // downstream stall: result must hold, no new accept
    run_op("add_hold", I_OPQ, F_ADDQ, 64'd2, 64'd3, 64'd0, 1'b0, 64'd5, 1'b0, 3'b000);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold_ov",    out_valid, 1'b1);
      check("hold_valE",  valE, 64'd5);
      check("hold_cnd",   cnd, 1'b0);
      check("hold_ready", in_ready, 1'b0);
    end
    exp_q.push_back(64'h55);
    icode = I_IRMOVQ; ifun = 4'h0; valC = 64'h55; cc_inhibit = 1'b0;
    in_valid = 1'b1;
    #1;
    check("stall_ready0", in_ready, 1'b0);
    out_ready = 1'b1;
    #1;
    check("stall_ready1", in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    check("irmov_ov",   out_valid, 1'b1);
    check("irmov_valE", valE, 64'h55);

    // inhibited CC update, then other icodes and conditions
    run_op("xor_inh", I_OPQ, F_XORQ, 64'd3, 64'd3, 64'd0, 1'b1, 64'd0, 1'b0, 3'b000);
    run_op("subq_ovf", I_OPQ, F_SUBQ, 64'd1, 64'h8000_0000_0000_0000, 64'd0, 1'b0,
           64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 3'b100);
    run_op("cmovg",  I_RRMOVQ, C_G, 64'd7, 64'd0, 64'd0, 1'b0, 64'd7, 1'b0, 3'b100);
    run_op("cmovl",  I_RRMOVQ, C_L, 64'd9, 64'd0, 64'd0, 1'b0, 64'd9, 1'b1, 3'b100);
    run_op("op_bad", I_OPQ, 4'h7, 64'd1, 64'd2, 64'd0, 1'b0, 64'd0, 1'b0, 3'b100);
    run_op("mrmov",  I_MRMOVQ, 4'h0, 64'd0, 64'h100, 64'h20, 1'b0, 64'h120, 1'b0, 3'b100);
    run_op("call",   I_CALL, 4'h0, 64'd0, 64'h1000, 64'd0, 1'b0, 64'hFF8, 1'b0, 3'b100);
    run_op("popq",   I_POPQ, 4'h0, 64'd0, 64'h1000, 64'd0, 1'b0, 64'h1008, 1'b0, 3'b100);
    run_op("halt",   I_HALT, 4'h0, 64'd1, 64'd2, 64'h77, 1'b0, 64'd0, 1'b0, 3'b100);
    run_op("jmp",    I_JXX, C_YES, 64'd0, 64'd0, 64'd0, 1'b0, 64'd0, 1'b1, 3'b100);
    run_op("andq_z", I_OPQ, F_ANDQ, 64'hF0, 64'h0F, 64'd0, 1'b0, 64'd0, 1'b0, 3'b001);
    run_op("jne",    I_JXX, C_NE, 64'd0, 64'd0, 64'd0, 1'b0, 64'd0, 1'b0, 3'b001);
    tick(); tick();
    check("sb_left", 64'(exp_q.size()), 64'd0);

    // W=16 mulq latency / busy profile
    ic_s = I_OPQ; if_s = F_MULQ; a_s = 16'h0100; b_s = 16'h0101; inh_s = 1'b0;
    iv_s = 1'b1;
    #1;
    check("mul_accept_ready", ir_s, 1'b1);
    tick();
    iv_s = 1'b0;
    busy_n = 0; rdy_seen = 1'b0; lat = -1;
    for (int k = 0; k < 40; k++) begin
      if (ov_s) begin
        lat = k;
        break;
      end
      if (busy_s) busy_n++;
      if (ir_s) rdy_seen = 1'b1;
      if (k == 1)  check("mul_state", st_s, ST_MUL);
      if (k == 16) check("mul_cc_pre", cc_s, 3'b001);
      tick();
    end
    check("mul_latency", 64'(lat), 64'd17);
    check("mul_busy_cycles", 64'(busy_n), 64'd16);
    check("mul_ready_low", rdy_seen, 1'b0);
    check("mul_valE", ve_s, 16'h0100);
    check("mul_cc", cc_s, 3'b000);
    check("mul_cnd", cnd_s, 1'b0);
    check("mul_busy_end", busy_s, 1'b0);

    // reset in the middle of a multiply
    ic_s = I_OPQ; if_s = F_MULQ; a_s = 16'd3; b_s = 16'd5;
    iv_s = 1'b1;
    tick();
    iv_s = 1'b0;
    tick(); tick(); tick(); tick();
    check("abort_busy_pre", busy_s, 1'b1);
    rst = 1'b1;
    tick();
    check("abort_ov",    ov_s, 1'b0);
    check("abort_busy",  busy_s, 1'b0);
    check("abort_cc",    cc_s, 3'b001);
    check("abort_ready", ir_s, 1'b0);
    rst = 1'b0;
    ov_seen = 1'b0;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (ov_s) ov_seen = 1'b1;
    end
    check("abort_no_result", ov_seen, 1'b0);
    check("abort_cc_after",  cc_s, 3'b001);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
